bird_control: RTL

BIRD_CONTROL -- requirements
Module: bird_control

---
 rtl/bird_pkg.sv | 55 +++++
 rtl/frame_tick_gen.sv | 33 +++
 rtl/bird_control.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bird_pkg.sv
// Shared definitions for the bird control FSM and the bird datapath:
// command codes, flight modes, FSM states and the direction LFSR step.
package bird_pkg;

    typedef enum logic [3:0] {
        CtrlHold      = 4'b0000,
        CtrlClear     = 4'b0001,
        CtrlUpLeft    = 4'b0010,
        CtrlUpRight   = 4'b0011,
        CtrlPrehold   = 4'b0100,
        CtrlDraw      = 4'b0101,
        CtrlDownRight = 4'b0110,
        CtrlDownLeft  = 4'b0111,
        CtrlShot      = 4'b1000,
        CtrlEscape    = 4'b1001
    } ctrl_e;

    typedef enum logic [1:0] {
        ModeFly  = 2'd0,
        ModeFall = 2'd1,
        ModeEsc  = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        StPrehold = 3'd0,
        StHold    = 3'd1,
        StClear   = 3'd2,
        StMove    = 3'd3,
        StDraw    = 3'd4
    } state_e;

    localparam logic [7:0] LfsrSeed = 8'hA5;

    // Fibonacci form of x^8+x^6+x^5+x^4+1; a nonzero seed never reaches zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic ctrl_e move_code(input mode_e mode, input logic dx, input logic dy);
        ctrl_e code;
        case (mode)
            ModeFall: code = CtrlShot;
            ModeEsc:  code = CtrlEscape;
            default: begin
                if (dy) begin
                    code = dx ? CtrlDownRight : CtrlDownLeft;
                end else begin
                    code = dx ? CtrlUpRight : CtrlUpLeft;
                end
            end
        endcase
        return code;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: one-cycle tick every FRAME_DIV clocks,
// restartable so a new bird starts on a fresh frame boundary.
module frame_tick_gen #(
    parameter int unsigned FRAME_DIV = 833333
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CntW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FRAME_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/bird_control.sv
// Bird control FSM: sequences per-frame clear/move/draw commands to the
// datapath, steers the bird and decides when it has been hit or escaped.
module bird_control
    import bird_pkg::*;
#(
    parameter int unsigned FRAME_DIV     = 833333,
    parameter int unsigned TURN_FRAMES   = 32,
    parameter int unsigned ESCAPE_FRAMES = 300,
    parameter int unsigned X_MAX         = 156,
    parameter int unsigned Y_MAX         = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       draw_done,
    input  logic       flying,
    input  logic       shot,
    input  logic [7:0] bird_x,
    input  logic [6:0] bird_y,
    output logic [3:0] control,
    output logic       hit,
    output logic       escaped
);
    localparam int unsigned TurnW = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;
    localparam int unsigned EscW  = (ESCAPE_FRAMES > 0) ? $clog2(ESCAPE_FRAMES + 1) : 1;
    localparam logic [TurnW-1:0] TurnLast = TurnW'(TURN_FRAMES - 1);
    localparam logic [EscW-1:0]  EscMax   = EscW'(ESCAPE_FRAMES);
    localparam logic [7:0]       XMax     = 8'(X_MAX);
    localparam logic [6:0]       YMax     = 7'(Y_MAX);

    state_e           state_q, state_d;
    ctrl_e            control_q, control_d;
    mode_e            mode_q, mode_d;
    logic             hit_q, hit_d;
    logic             escaped_q, escaped_d;
    logic             dx_q, dx_d;
    logic             dy_q, dy_d;
    logic             pending_q, pending_d;
    logic             seen_q, seen_d;
    logic [TurnW-1:0] turn_q, turn_d;
    logic [EscW-1:0]  esc_q, esc_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             launch;
    logic             tick;

    assign launch = (state_q == StPrehold) && start;

    frame_tick_gen #(
        .FRAME_DIV(FRAME_DIV)
    ) u_frame_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (launch),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        hit_d     = 1'b0;
        escaped_d = 1'b0;
        dx_d      = dx_q;
        dy_d      = dy_q;
        turn_d    = turn_q;
        esc_d     = esc_q;
        seen_d    = seen_q | ((mode_q != ModeFly) && flying);
        pending_d = pending_q | tick;
        lfsr_d    = lfsr_step(lfsr_q);

        unique case (state_q)
            StPrehold: begin
                if (start) begin
                    state_d   = StHold;
                    mode_d    = ModeFly;
                    turn_d    = '0;
                    esc_d     = '0;
                    seen_d    = 1'b0;
                    // Frame phase restarts at launch, so a stale tick must not fire early.
                    pending_d = 1'b0;
                end
            end
            StHold: begin
                if (pending_q) begin
                    state_d   = StClear;
                    pending_d = 1'b0;
                end
            end
            StClear: begin
                if (draw_done) begin
                    state_d = StMove;
                    if (mode_q == ModeFly) begin
                        if (turn_q == TurnLast) begin
                            {dx_d, dy_d} = lfsr_q[1:0];
                            turn_d       = '0;
                        end else begin
                            turn_d = turn_q + 1'b1;
                        end
                        // Screen edges override any random turn.
                        if (bird_x >= XMax) begin
                            dx_d = 1'b0;
                        end else if (bird_x == 8'd0) begin
                            dx_d = 1'b1;
                        end
                        if (bird_y == 7'd0) begin
                            dy_d = 1'b1;
                        end else if (bird_y >= YMax) begin
                            dy_d = 1'b0;
                        end
                    end
                end
            end
            StMove: begin
                state_d = StDraw;
            end
            StDraw: begin
                if (draw_done) begin
                    state_d = StHold;
                    if (mode_q == ModeFly) begin
                        if (esc_q != EscMax) begin
                            esc_d = esc_q + 1'b1;
                        end
                        if (shot) begin
                            mode_d = ModeFall;
                        end else if (esc_d == EscMax) begin
                            mode_d = ModeEsc;
                        end
                    end else if (seen_q && !flying) begin
                        state_d   = StPrehold;
                        hit_d     = (mode_q == ModeFall);
                        escaped_d = (mode_q == ModeEsc);
                    end
                end
            end
            default: state_d = StPrehold;
        endcase

        case (state_d)
            StHold:  control_d = CtrlHold;
            StClear: control_d = CtrlClear;
            StMove:  control_d = move_code(mode_d, dx_d, dy_d);
            StDraw:  control_d = CtrlDraw;
            default: control_d = CtrlPrehold;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StPrehold;
            control_q <= CtrlPrehold;
            mode_q    <= ModeFly;
            hit_q     <= 1'b0;
            escaped_q <= 1'b0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b0;
            pending_q <= 1'b0;
            seen_q    <= 1'b0;
            turn_q    <= '0;
            esc_q     <= '0;
            lfsr_q    <= LfsrSeed;
        end else begin
            state_q   <= state_d;
            control_q <= control_d;
            mode_q    <= mode_d;
            hit_q     <= hit_d;
            escaped_q <= escaped_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            pending_q <= pending_d;
            seen_q    <= seen_d;
            turn_q    <= turn_d;
            esc_q     <= esc_d;
            lfsr_q    <= lfsr_d;
        end
    end

    assign control = control_q;
    assign hit     = hit_q;
    assign escaped = escaped_q;

endmodule
